// File: rtl/multicycle_control_if.sv
// Datapath-facing bundle for the multicycle MIPS main controller: opcode and memory
// handshake in, mux selects / write enables / debug state out.
interface multicycle_control_if #(
  parameter int STATE_W = 4
);
  logic [5:0]         Opcode;
  logic               MemReady;
  logic               PCWrite;
  logic               PCWriteCond;
  logic               IorD;
  logic               MemRead;
  logic               MemWrite;
  logic               MemtoReg;
  logic               IRWrite;
  logic               RegWrite;
  logic               RegDst;
  logic               ALUSrcA;
  logic               ALUOp1;
  logic               ALUOp0;
  logic [1:0]         ALUSrcB;
  logic [1:0]         PCSource;
  logic               Illegal;
  logic [STATE_W-1:0] State;

  modport master (
    input  Opcode, MemReady,
    output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite,
           RegWrite, RegDst, ALUSrcA, ALUOp1, ALUOp0, ALUSrcB, PCSource,
           Illegal, State
  );

  modport slave (
    output Opcode, MemReady,
    input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite,
           RegWrite, RegDst, ALUSrcA, ALUOp1, ALUOp0, ALUSrcB, PCSource,
           Illegal, State
  );
endinterface

// File: rtl/multicycle_control.sv
// Main control FSM of the multicycle MIPS datapath (R-type, lw, sw, beq; j when the
// MC_CTRL_JUMP_EN macro is defined). Memory states wait on MemReady.
module multicycle_control #(
  parameter int STATE_W = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  multicycle_control_if.master  bus
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_RWB    = 4'd7,
`ifdef MC_CTRL_JUMP_EN
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9
`else
    S_BRANCH = 4'd8
`endif
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
`ifdef MC_CTRL_JUMP_EN
  localparam logic [5:0] OP_J     = 6'b000010;
`endif

  state_t state_reg;
  state_t state_next;

  logic       pcwrite_c, pcwritecond_c, iord_c, memread_c, memwrite_c, memtoreg_c;
  logic       irwrite_c, regwrite_c, regdst_c, alusrca_c, aluop1_c, aluop0_c, illegal_c;
  logic [1:0] alusrcb_c, pcsource_c;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= S_FETCH;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    pcwrite_c     = 1'b0;
    pcwritecond_c = 1'b0;
    iord_c        = 1'b0;
    memread_c     = 1'b0;
    memwrite_c    = 1'b0;
    memtoreg_c    = 1'b0;
    irwrite_c     = 1'b0;
    regwrite_c    = 1'b0;
    regdst_c      = 1'b0;
    alusrca_c     = 1'b0;
    aluop1_c      = 1'b0;
    aluop0_c      = 1'b0;
    illegal_c     = 1'b0;
    alusrcb_c     = 2'b00;
    pcsource_c    = 2'b00;

    case (state_reg)
      S_FETCH: begin
        memread_c = 1'b1;
        alusrcb_c = 2'b01;
        irwrite_c = bus.MemReady;
        pcwrite_c = bus.MemReady;
        if (bus.MemReady) state_next = S_DECODE;
      end
      S_DECODE: begin
        alusrcb_c = 2'b11;
        case (bus.Opcode)
          OP_RTYPE:     state_next = S_EXEC;
          OP_LW, OP_SW: state_next = S_MEMADR;
          OP_BEQ:       state_next = S_BRANCH;
`ifdef MC_CTRL_JUMP_EN
          OP_J:         state_next = S_JUMP;
`endif
          default: begin
            state_next = S_FETCH;
            illegal_c  = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        alusrca_c  = 1'b1;
        alusrcb_c  = 2'b10;
        state_next = (bus.Opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        memread_c = 1'b1;
        iord_c    = 1'b1;
        if (bus.MemReady) state_next = S_MEMWB;
      end
      S_MEMWB: begin
        regwrite_c = 1'b1;
        memtoreg_c = 1'b1;
        state_next = S_FETCH;
      end
      S_MEMWR: begin
        // The write strobe is held for the whole wait, not just the completing cycle.
        memwrite_c = 1'b1;
        iord_c     = 1'b1;
        if (bus.MemReady) state_next = S_FETCH;
      end
      S_EXEC: begin
        alusrca_c  = 1'b1;
        aluop1_c   = 1'b1;
        state_next = S_RWB;
      end
      S_RWB: begin
        regwrite_c = 1'b1;
        regdst_c   = 1'b1;
        state_next = S_FETCH;
      end
      S_BRANCH: begin
        alusrca_c     = 1'b1;
        aluop0_c      = 1'b1;
        pcwritecond_c = 1'b1;
        pcsource_c    = 2'b01;
        state_next    = S_FETCH;
      end
`ifdef MC_CTRL_JUMP_EN
      S_JUMP: begin
        pcwrite_c  = 1'b1;
        pcsource_c = 2'b10;
        state_next = S_FETCH;
      end
`endif
      default: state_next = S_FETCH;
    endcase
  end

  // Gating with reset_n makes every strobe drop the instant reset asserts,
  // rather than waiting for the state register to settle.
  assign bus.PCWrite     = reset_n & pcwrite_c;
  assign bus.PCWriteCond = reset_n & pcwritecond_c;
  assign bus.IorD        = reset_n & iord_c;
  assign bus.MemRead     = reset_n & memread_c;
  assign bus.MemWrite    = reset_n & memwrite_c;
  assign bus.MemtoReg    = reset_n & memtoreg_c;
  assign bus.IRWrite     = reset_n & irwrite_c;
  assign bus.RegWrite    = reset_n & regwrite_c;
  assign bus.RegDst      = reset_n & regdst_c;
  assign bus.ALUSrcA     = reset_n & alusrca_c;
  assign bus.ALUOp1      = reset_n & aluop1_c;
  assign bus.ALUOp0      = reset_n & aluop0_c;
  assign bus.Illegal     = reset_n & illegal_c;
  assign bus.ALUSrcB     = {2{reset_n}} & alusrcb_c;
  assign bus.PCSource    = {2{reset_n}} & pcsource_c;
  assign bus.State       = STATE_W'(state_reg);

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: directed instructions, then random
// instruction/wait mixes, each checked cycle by cycle against an expected trace.
module tb_multicycle_control;

  logic clk;
  logic reset_n;
  int   checks;
  int   errors;

  multicycle_control_if #(.STATE_W(4)) bus ();

  multicycle_control #(.STATE_W(4)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Control vector: PCWrite PCWriteCond IorD MemRead MemWrite MemtoReg IRWrite
  // RegWrite RegDst ALUSrcA ALUOp1 ALUOp0 ALUSrcB[1:0] PCSource[1:0] Illegal
  localparam logic [16:0] PCW  = 17'h10000;
  localparam logic [16:0] PCWC = 17'h08000;
  localparam logic [16:0] IORD = 17'h04000;
  localparam logic [16:0] MRD  = 17'h02000;
  localparam logic [16:0] MWR  = 17'h01000;
  localparam logic [16:0] MTR  = 17'h00800;
  localparam logic [16:0] IRW  = 17'h00400;
  localparam logic [16:0] RW   = 17'h00200;
  localparam logic [16:0] RDST = 17'h00100;
  localparam logic [16:0] SRCA = 17'h00080;
  localparam logic [16:0] AOP1 = 17'h00040;
  localparam logic [16:0] AOP0 = 17'h00020;
  localparam logic [16:0] SB01 = 17'h00008;
  localparam logic [16:0] SB10 = 17'h00010;
  localparam logic [16:0] SB11 = 17'h00018;
  localparam logic [16:0] PS01 = 17'h00002;
  localparam logic [16:0] PS10 = 17'h00004;
  localparam logic [16:0] ILL  = 17'h00001;

  logic [16:0] obs_ctl;
  assign obs_ctl = {bus.PCWrite, bus.PCWriteCond, bus.IorD, bus.MemRead, bus.MemWrite,
                    bus.MemtoReg, bus.IRWrite, bus.RegWrite, bus.RegDst, bus.ALUSrcA,
                    bus.ALUOp1, bus.ALUOp0, bus.ALUSrcB, bus.PCSource, bus.Illegal};

  // Expected trace: one entry per clock cycle of the instruction.
  int          q_st[$];
  logic [16:0] q_ctl[$];
  bit          q_rdy[$];
  logic [5:0]  q_op[$];
  int          instr_no;

  task automatic push(input int st, input logic [16:0] c, input bit r, input logic [5:0] op);
    q_st.push_back(st);
    q_ctl.push_back(c);
    q_rdy.push_back(r);
    q_op.push_back(op);
  endtask

  task automatic check(input string tag, input logic [16:0] obs, input logic [16:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s instr %0d observed %0h expected %0h", tag, instr_no, obs, exp);
    end
  endtask

  // Expected behaviour of one instruction with fw FETCH waits and mw memory waits.
  task automatic build(input logic [5:0] op, input int fw, input int mw);
    bit is_r, is_lw, is_sw, is_beq, is_j, ill;
    is_r   = (op == 6'b000000);
    is_lw  = (op == 6'b100011);
    is_sw  = (op == 6'b101011);
    is_beq = (op == 6'b000100);
    is_j   = 1'b0;
`ifdef MC_CTRL_JUMP_EN
    is_j   = (op == 6'b000010);
`endif
    ill = !(is_r || is_lw || is_sw || is_beq || is_j);
    for (int i = 0; i < fw; i++) push(0, MRD | SB01, 1'b0, 6'($urandom));
    push(0, MRD | SB01 | PCW | IRW, 1'b1, 6'($urandom));
    push(1, SB11 | (ill ? ILL : 17'h0), 1'($urandom), op);
    if (is_r) begin
      push(6, SRCA | AOP1, 1'($urandom), op);
      push(7, RW | RDST, 1'($urandom), op);
    end else if (is_lw) begin
      push(2, SRCA | SB10, 1'($urandom), op);
      for (int i = 0; i < mw; i++) push(3, MRD | IORD, 1'b0, op);
      push(3, MRD | IORD, 1'b1, op);
      push(4, RW | MTR, 1'($urandom), op);
    end else if (is_sw) begin
      push(2, SRCA | SB10, 1'($urandom), op);
      for (int i = 0; i < mw; i++) push(5, MWR | IORD, 1'b0, op);
      push(5, MWR | IORD, 1'b1, op);
    end else if (is_beq) begin
      push(8, SRCA | AOP0 | PCWC | PS01, 1'($urandom), op);
    end else if (is_j) begin
      push(9, PCW | PS10, 1'($urandom), op);
    end
  endtask

  // Plays the queued trace; with abort set, reset is pulsed during the first MEMWR wait.
  task automatic run_trace(input bit abort_memwr);
    int          st;
    logic [16:0] c;
    while (q_st.size() > 0) begin
      st = q_st.pop_front();
      c  = q_ctl.pop_front();
      @(negedge clk);
      bus.MemReady = q_rdy.pop_front();
      bus.Opcode   = q_op.pop_front();
      #1;
      check($sformatf("state_in_%0d", st), 17'(bus.State), 17'(st));
      check($sformatf("ctl_in_%0d", st), obs_ctl, c);
      if (abort_memwr && st == 5 && !bus.MemReady) begin
        #1 reset_n = 1'b0;
        #1;
        check("rst_memwr_ctl", obs_ctl, 17'h0);
        check("rst_memwr_state", 17'(bus.State), 17'h0);
        @(posedge clk);
        #1;
        check("rst_hold_ctl", obs_ctl, 17'h0);
        @(negedge clk);
        bus.MemReady = 1'b0;
        reset_n      = 1'b1;
        #1;
        check("rst_release_state", 17'(bus.State), 17'h0);
        check("rst_release_ctl", obs_ctl, MRD | SB01);
        q_st.delete();
        q_ctl.delete();
        q_rdy.delete();
        q_op.delete();
      end
    end
  endtask

  initial begin
    logic [5:0] op;
    int         pick;
    checks       = 0;
    errors       = 0;
    instr_no     = 0;
    reset_n      = 1'b0;
    bus.MemReady = 1'b1;
    bus.Opcode   = 6'b100011;

    // Outputs held at zero throughout reset, even with MemReady high.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      check("reset_ctl", obs_ctl, 17'h0);
      check("reset_state", 17'(bus.State), 17'h0);
    end
    @(negedge clk);
    bus.MemReady = 1'b0;
    reset_n      = 1'b1;

    // Directed instructions from the test plan.
    instr_no = 1; build(6'b000000, 0, 0); run_trace(1'b0);
    instr_no = 2; build(6'b100011, 0, 2); run_trace(1'b0);
    instr_no = 3; build(6'b101011, 0, 0); run_trace(1'b0);
    instr_no = 4; build(6'b000100, 0, 0); run_trace(1'b0);
    instr_no = 5; build(6'b000000, 3, 0); run_trace(1'b0);
    instr_no = 6; build(6'b000010, 0, 0); run_trace(1'b0);
    instr_no = 7; build(6'b111111, 1, 0); run_trace(1'b0);
    instr_no = 8; build(6'b101011, 0, 3); run_trace(1'b1);
    instr_no = 9; build(6'b100011, 1, 1); run_trace(1'b0);

    // Random mix of instruction kinds and wait lengths.
    for (int n = 0; n < 200; n++) begin
      instr_no = 100 + n;
      pick = $urandom_range(0, 6);
      case (pick)
        0: op = 6'b000000;
        1: op = 6'b100011;
        2: op = 6'b101011;
        3: op = 6'b000100;
        4: op = 6'b000010;
        5: op = 6'b111111;
        default: op = 6'($urandom);
      endcase
      build(op, $urandom_range(0, 3), $urandom_range(0, 3));
      run_trace(n % 50 == 25);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Main control FSM for the multicycle MIPS datapath, directly upstream of `alu_control`. It sequences every instruction through fetch, decode, execute, memory and write-back states, and drives the datapath mux selects and write enables. It also produces the `ALUOp1`/`ALUOp0` pair that `alu_control` combines with `Funct`. It supports R-type, lw, sw and beq, plus j when the jump feature is compiled in. Memory accesses wait on a `MemReady` handshake.

## Interface
- `STATE_W`, default 4: width of the `State` debug output; must be ≥4; upper bits are zero.

Ports (clock and reset first):
- `clk` in 1: rising-edge clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `Opcode` in 6: `IR[31:26]`; valid from DECODE onward.
- `MemReady` in 1: memory has completed the current read or write this cycle.
- `PCWrite`, `PCWriteCond`, `IorD`, `MemRead`, `MemWrite`, `MemtoReg`, `IRWrite`, `RegWrite`, `RegDst`, `ALUSrcA` out 1: standard multicycle controls.
- `ALUOp1`, `ALUOp0` out 1: to `alu_control`.
- `ALUSrcB` out 2: ALU B-input select.
- `PCSource` out 2: next-PC select.
- `Illegal` out 1: unrecognised opcode in DECODE.
- `State` out `STATE_W`: current state encoding.

## Operation
- State register encoding: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, RWB=7, BRANCH=8, JUMP=9.
- Outputs decode from the state register. `IRWrite`, `PCWrite`, `Illegal` are additionally qualified by inputs as listed below. Every output not listed for a state is 0.
- FETCH: `MemRead`=1, `ALUSrcB`=01.
  - `IRWrite`=`PCWrite`=`MemReady`.
  - Stay while `MemReady`=0; go to DECODE when it is 1.
- DECODE: `ALUSrcB`=11. Next state by opcode:
  - 000000 → EXEC.
  - 100011 or 101011 → MEMADR.
  - 000100 → BRANCH.
  - 000010 → JUMP (see Configuration).
  - Any other value → FETCH with `Illegal`=1 for this cycle.
- MEMADR: `ALUSrcA`=1, `ALUSrcB`=10. Opcode 100011 → MEMRD; otherwise → MEMWR.
- MEMRD: `MemRead`=1, `IorD`=1. Hold until `MemReady`, then → MEMWB.
- MEMWB: `RegWrite`=1, `MemtoReg`=1, `RegDst`=0 → FETCH.
- MEMWR: `MemWrite`=1, `IorD`=1. Hold until `MemReady`, then → FETCH. `MemWrite` stays high for every wait cycle.
- EXEC: `ALUSrcA`=1, `ALUSrcB`=00, `ALUOp1`=1, `ALUOp0`=0 → RWB.
- RWB: `RegWrite`=1, `RegDst`=1, `MemtoReg`=0 → FETCH.
- BRANCH: `ALUSrcA`=1, `ALUOp0`=1, `PCWriteCond`=1, `PCSource`=01 → FETCH.
- JUMP: `PCWrite`=1, `PCSource`=10 → FETCH.
- Encodings 10–15 are unreachable; if entered, next state is FETCH and all outputs are 0.

## Timing
- Reset:
  - While `reset_n`=0, the state is FETCH and every output is forced to 0, including `MemRead`, `IRWrite` and `PCWrite`.
  - Deassertion is sampled on the next `clk` rise; the first active cycle is FETCH.
- Reset mid-instruction (including MEMWR wait):
  - All write enables drop immediately.
  - No partial write-back occurs after release.
- Cycle counts with zero memory wait:
  - R-type 4, lw 5, sw 4, beq 3, j 3, illegal 2.
  - Each cycle with `MemReady`=0 in FETCH, MEMRD or MEMWR adds exactly one cycle.
- `MemReady` outside FETCH, MEMRD and MEMWR is ignored.
- `Opcode` is sampled only in DECODE and MEMADR. It must stay stable from DECODE until the instruction returns to FETCH (IR not rewritten).
- `Illegal` is high for exactly one cycle per illegal instruction.

## Configuration
- `MC_CTRL_JUMP_EN` defined: opcode 000010 goes DECODE → JUMP → FETCH. JUMP drives `PCWrite`=1, `PCSource`=10.
- `MC_CTRL_JUMP_EN` undefined:
  - The JUMP state is not built.
  - Opcode 000010 is illegal (DECODE → FETCH, `Illegal`=1).
  - `PCSource` never takes the value 10.

## Test plan
- Reset: hold `reset_n`=0, toggle `clk` → all outputs 0, `State`=0. Drop `reset_n` mid-MEMWR → `MemWrite` falls immediately; after release `State`=0.
- R-type, `MemReady`=1: `Opcode`=000000 → states 0,1,6,7,0. In EXEC, `ALUOp1`/`ALUOp0`=1/0. In RWB, `RegWrite`=1, `RegDst`=1.
- lw with 2 wait cycles in MEMRD: `Opcode`=100011 → states 0,1,2,3,3,3,4,0. `MemRead`=`IorD`=1 for three cycles, then `MemtoReg`=`RegWrite`=1.
- sw and beq: 101011 → 0,1,2,5,0 with one `MemWrite` cycle. 000100 → 0,1,8,0 with `ALUOp0`=1, `PCWriteCond`=1, `PCSource`=01.
- Fetch wait: `MemReady`=0 for 3 cycles in FETCH → `IRWrite`=`PCWrite`=0 throughout; both are 1 on the cycle `MemReady` rises.
- Opcode 000010, and 111111: with the macro, 000010 → 0,1,9,0 with `PCWrite`=1, `PCSource`=10. Without the macro, 000010 → 0,1,0 with one-cycle `Illegal`=1. 111111 → 0,1,0 with `Illegal`=1 in both builds.
